// File: rtl/dm_abstract_cmd.sv
// dm_abstract_cmd: sequences Access Register abstract commands onto the core GPR debug port.
module dm_abstract_cmd #(
  parameter int          XLEN     = 32,
  parameter logic [15:0] GPR_BASE = 16'h1000
) (
  input  logic            clk,
  input  logic            sys_reset,
  input  logic            CmdValid,
  input  logic [31:0]     Command,
  input  logic [XLEN-1:0] Data0In,
  input  logic [2:0]      CmdErrClr,
  input  logic            DebugMode,
  input  logic [XLEN-1:0] RegOut,
  output logic            CmdBusy,
  output logic [2:0]      CmdErr,
  output logic            CmdDone,
  output logic [XLEN-1:0] Data0Out,
  output logic            Data0WrEn,
  output logic            DebugControl,
  output logic [4:0]      RegAddr,
  output logic [XLEN-1:0] RegIn,
  output logic            DebugRegWrite
);
  typedef enum logic [1:0] {IDLE, DECODE, EXEC, DONE} state_t;
  state_t          r_state;
  logic [31:0]     r_cmd;
  logic [XLEN-1:0] r_data, r_d0out;
  logic [2:0]      r_err;
  logic            r_rd_ok;
  logic [16:0]     w_off;
  logic            w_gpr, w_exec, w_rd, w_busy_err, w_unused;
  logic [2:0]      w_dec_err, w_set;
  // Offset from x0; any bit above [4:0] set means regno lies outside the GPR window.
  assign w_off      = {1'b0, r_cmd[15:0]} - {1'b0, GPR_BASE};
  assign w_gpr      = w_off[16:5] == '0;
  assign w_dec_err  = !DebugMode ? 3'd4 :
                      (r_cmd[31:24] != '0 || r_cmd[18] ||
                       (r_cmd[17] && (r_cmd[22:20] != 3'd2 || !w_gpr))) ? 3'd2 : 3'd0;
  assign w_exec     = r_state == EXEC;
  assign w_rd       = w_exec && !r_cmd[16] && DebugMode;
  assign w_set      = r_state == DECODE ? w_dec_err : (w_exec && !DebugMode) ? 3'd4 : 3'd0;
  assign w_busy_err = CmdValid && r_state != IDLE && r_err == '0;
  assign w_unused   = ^{r_cmd[23], r_cmd[19]};
  always_ff @(posedge clk) begin
    if (sys_reset) begin
      r_state <= IDLE;
      r_cmd   <= '0;
      r_data  <= '0;
      r_d0out <= '0;
      r_err   <= '0;
      r_rd_ok <= 1'b0;
    end else begin
      r_err   <= w_set != '0 ? w_set : w_busy_err ? 3'd1 : r_err & ~CmdErrClr;
      r_rd_ok <= w_rd;
      if (w_rd) r_d0out <= RegOut;
      case (r_state)
        IDLE: if (CmdValid && r_err == '0) begin
          r_cmd   <= Command;
          r_data  <= Data0In;
          r_state <= DECODE;
        end
        DECODE:  r_state <= (w_dec_err != '0 || !r_cmd[17]) ? DONE : EXEC;
        EXEC:    r_state <= DONE;
        default: r_state <= IDLE;
      endcase
    end
  end
  assign CmdBusy       = r_state != IDLE;
  assign CmdErr        = r_err;
  assign CmdDone       = r_state == DONE;
  assign Data0Out      = r_d0out;
  assign Data0WrEn     = CmdDone && r_rd_ok;
  assign DebugControl  = w_exec;
  assign RegAddr       = w_exec ? w_off[4:0] : '0;
  assign RegIn         = (w_exec && r_cmd[16]) ? r_data : '0;
  assign DebugRegWrite = w_exec && r_cmd[16] && DebugMode && w_off[4:0] != '0;
endmodule

// File: tb/tb_dm_abstract_cmd.sv
// tb_dm_abstract_cmd: directed stimulus against a transaction-scheduled model of dm_abstract_cmd.
module tb_dm_abstract_cmd;
  logic        clk = 1'b0;
  logic        sys_reset = 1'b1;
  logic        CmdValid = 1'b0;
  logic [31:0] Command = '0;
  logic [31:0] Data0In = '0;
  logic [2:0]  CmdErrClr = '0;
  logic        DebugMode = 1'b1;
  logic [31:0] RegOut = '0;
  logic        CmdBusy, CmdDone, Data0WrEn, DebugControl, DebugRegWrite;
  logic [2:0]  CmdErr;
  logic [31:0] Data0Out, RegIn;
  logic [4:0]  RegAddr;

  dm_abstract_cmd dut (
    .clk(clk), .sys_reset(sys_reset), .CmdValid(CmdValid), .Command(Command),
    .Data0In(Data0In), .CmdErrClr(CmdErrClr), .DebugMode(DebugMode), .RegOut(RegOut),
    .CmdBusy(CmdBusy), .CmdErr(CmdErr), .CmdDone(CmdDone), .Data0Out(Data0Out),
    .Data0WrEn(Data0WrEn), .DebugControl(DebugControl), .RegAddr(RegAddr),
    .RegIn(RegIn), .DebugRegWrite(DebugRegWrite)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Expected per-cycle outputs, indexed by the cycle number following each rising edge.
  bit        e_busy[4096], e_done[4096], e_wren[4096], e_ctl[4096], e_wr[4096];
  bit [4:0]  e_addr[4096];
  bit [31:0] e_rin[4096];
  int          cyc = 0;
  int          pst = 0;
  int          at = 0;
  logic [31:0] p_cmd = '0, p_d0 = '0;
  logic [2:0]  m_err = '0;
  logic [31:0] m_d0 = '0;

  function automatic logic [2:0] classify(input logic [31:0] c, input logic dm);
    int r;
    r = int'(c[15:0]);
    if (!dm) return 3'd4;
    if (c[31:24] != 8'd0 || c[18]) return 3'd2;
    if (c[17] && (c[22:20] != 3'd2 || r < 'h1000 || r > 'h101F)) return 3'd2;
    return 3'd0;
  endfunction

  always @(posedge clk) begin
    int n;
    logic [2:0] ne, code;
    logic [4:0] idx;
    cyc = cyc + 1;
    n = cyc;
    if (sys_reset) begin
      m_err = '0;
      m_d0  = '0;
      pst   = 0;
      for (int i = 0; i < 4; i++) begin
        e_busy[n+i] = 0; e_done[n+i] = 0; e_wren[n+i] = 0; e_ctl[n+i] = 0;
        e_wr[n+i] = 0; e_addr[n+i] = '0; e_rin[n+i] = '0;
      end
    end else begin
      ne = m_err & ~CmdErrClr;
      if (CmdValid && e_busy[n-1] && m_err == '0) ne = 3'd1;
      if (pst == 1 && at == n) begin
        code = classify(p_cmd, DebugMode);
        idx = 5'(p_cmd[15:0] - 16'h1000);
        e_busy[n] = 1;
        if (code != '0 || !p_cmd[17]) begin
          e_done[n] = 1;
          if (code != '0) ne = code;
          pst = 0;
        end else begin
          e_busy[n+1] = 1; e_done[n+1] = 1;
          e_ctl[n] = 1; e_addr[n] = idx;
          e_rin[n] = p_cmd[16] ? p_d0 : '0;
          e_wr[n] = p_cmd[16] && idx != '0;
          pst = 2; at = n + 1;
        end
      end else if (pst == 2 && at == n) begin
        if (!DebugMode) ne = 3'd4;
        else if (!p_cmd[16]) begin m_d0 = RegOut; e_wren[n] = 1; end
        pst = 0;
      end
      if (CmdValid && !e_busy[n-1] && m_err == '0) begin
        p_cmd = Command; p_d0 = Data0In; pst = 1; at = n + 1; e_busy[n] = 1;
      end
      m_err = ne;
    end
  end

  always @(negedge clk) begin
    chk("busy", 32'(CmdBusy), 32'(e_busy[cyc]));
    chk("done", 32'(CmdDone), 32'(e_done[cyc]));
    chk("wren", 32'(Data0WrEn), 32'(e_wren[cyc]));
    chk("ctl", 32'(DebugControl), 32'(e_ctl[cyc]));
    chk("addr", 32'(RegAddr), 32'(e_ctl[cyc] ? e_addr[cyc] : 5'd0));
    chk("regin", RegIn, e_ctl[cyc] ? e_rin[cyc] : 32'd0);
    chk("regwr", 32'(DebugRegWrite), 32'(e_wr[cyc] && DebugMode));
    chk("cmderr", 32'(CmdErr), 32'(m_err));
    chk("data0", Data0Out, m_d0);
  end

  task automatic step(input int k = 1);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] c, input logic [31:0] d);
    CmdValid = 1'b1; Command = c; Data0In = d;
    step();
    CmdValid = 1'b0;
  endtask

  task automatic clr();
    CmdErrClr = 3'b111;
    step();
    CmdErrClr = 3'b000;
  endtask

  logic [31:0] bad[4] = '{32'h0033_1005, 32'h0022_0300, 32'h0026_1005, 32'h0122_1005};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    step(3);
    sys_reset = 1'b0;
    step();
    chk("lit_reset_busy", 32'(CmdBusy), 32'd0);
    chk("lit_reset_err", 32'(CmdErr), 32'd0);
    RegOut = 32'hDEADBEEF;
    issue(32'h0022_100A, 32'h0);
    step();
    chk("lit_rd_addr", 32'(RegAddr), 32'd10);
    chk("lit_rd_ctl", 32'(DebugControl), 32'd1);
    step();
    chk("lit_rd_data", Data0Out, 32'hDEADBEEF);
    chk("lit_rd_wren", 32'(Data0WrEn), 32'd1);
    chk("lit_rd_done", 32'(CmdDone), 32'd1);
    step();
    issue(32'h0023_1005, 32'h1234_5678);
    step();
    chk("lit_wr_strobe", 32'(DebugRegWrite), 32'd1);
    chk("lit_wr_data", RegIn, 32'h1234_5678);
    chk("lit_wr_addr", 32'(RegAddr), 32'd5);
    step(2);
    issue(32'h0023_1000, 32'hAAAA_5555);
    step();
    chk("lit_x0_nostrobe", 32'(DebugRegWrite), 32'd0);
    step(2);
    chk("lit_x0_err", 32'(CmdErr), 32'd0);
    DebugMode = 1'b0;
    issue(32'h0022_100A, 32'h0);
    step();
    chk("lit_halt_done", 32'(CmdDone), 32'd1);
    chk("lit_halt_err", 32'(CmdErr), 32'd4);
    step();
    issue(32'h0022_100A, 32'h0);
    chk("lit_ignored", 32'(CmdBusy), 32'd0);
    clr();
    chk("lit_cleared", 32'(CmdErr), 32'd0);
    DebugMode = 1'b1;
    foreach (bad[i]) begin
      issue(bad[i], 32'h0);
      step();
      chk("lit_bad_err", 32'(CmdErr), 32'd2);
      chk("lit_bad_done", 32'(CmdDone), 32'd1);
      clr();
    end
    issue(32'h0020_1005, 32'h0);
    step();
    chk("lit_nox_done", 32'(CmdDone), 32'd1);
    chk("lit_nox_err", 32'(CmdErr), 32'd0);
    step();
    RegOut = 32'h0000_5555;
    issue(32'h0022_1003, 32'h0);
    step();
    CmdValid = 1'b1; Command = 32'h0022_100A;
    step();
    CmdValid = 1'b0;
    chk("lit_busy_err", 32'(CmdErr), 32'd1);
    chk("lit_busy_data", Data0Out, 32'h0000_5555);
    step();
    clr();
    DebugMode = 1'b0;
    issue(32'h0022_100A, 32'h0);
    CmdErrClr = 3'b111;
    step();
    CmdErrClr = 3'b000;
    chk("lit_set_beats_clr", 32'(CmdErr), 32'd4);
    step();
    clr();
    DebugMode = 1'b1;
    RegOut = 32'h0000_0077;
    issue(32'h0022_100A, 32'h0);
    step();
    DebugMode = 1'b0;
    step();
    chk("lit_drop_err", 32'(CmdErr), 32'd4);
    chk("lit_drop_wren", 32'(Data0WrEn), 32'd0);
    DebugMode = 1'b1;
    step();
    clr();
    issue(32'h0023_1007, 32'h0000_CAFE);
    step();
    chk("lit_rst_pre_strobe", 32'(DebugRegWrite), 32'd1);
    sys_reset = 1'b1;
    step();
    sys_reset = 1'b0;
    chk("lit_rst_busy", 32'(CmdBusy), 32'd0);
    chk("lit_rst_strobe", 32'(DebugRegWrite), 32'd0);
    chk("lit_rst_data", Data0Out, 32'd0);
    step(4);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
